// File: rtl/serial_operand_shifter_if.sv
// Bundle between the operand shifter and its user (operand source plus serial adder).
// Carries the start/operand load request, the serial x/y bits and the frame status flags.
// SUM_CAPTURE_EN adds the adder sum input and the captured parallel sum outputs.
interface serial_operand_shifter_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         x;
    logic         y;
    logic         busy;
    logic         last;
    logic         done;
`ifdef SUM_CAPTURE_EN
    logic         s;
    logic [N:0]   sum;
    logic         sum_valid;
`endif

`ifdef SUM_CAPTURE_EN
    // Requester side: operand source and the serial adder feeding s back.
    modport master (
        output start, a, b, s,
        input  ready, x, y, busy, last, done, sum, sum_valid
    );

    // Shifter side.
    modport slave (
        input  start, a, b, s,
        output ready, x, y, busy, last, done, sum, sum_valid
    );
`else
    // Requester side: operand source.
    modport master (
        output start, a, b,
        input  ready, x, y, busy, last, done
    );

    // Shifter side.
    modport slave (
        input  start, a, b,
        output ready, x, y, busy, last, done
    );
`endif
endinterface

// File: rtl/serial_operand_shifter.sv
// Loads two N-bit operands on start and shifts them LSB-first to a serial adder, then one zero flush cycle.
// Latency: x/y show bit 0 one edge after the accepted start; frame is N SHIFT + 1 FLUSH cycles (period N+2 back-to-back).
// Backpressure: start is taken only while ready=1 (IDLE); start while busy is dropped, never queued.
// Optional feature macro: SUM_CAPTURE_EN (collects the adder's s bits into a parallel N+1 bit sum).
module serial_operand_shifter #(
    parameter int N = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    serial_operand_shifter_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  sa;
    logic [N-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          ready_q;
    logic          busy_q;
    logic          last_q;
    logic          done_q;

    // x/y are the low bits of the shift registers; zero fill leaves them 0 in FLUSH and IDLE,
    // so the serial outputs come straight from flops with no path from start.
    assign bus.x     = sa[0];
    assign bus.y     = sb[0];
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.last  = last_q;
    assign bus.done  = done_q;

    // Frame sequencer: load, N shifts, one flush cycle; status flags registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa      <= bus.a;
                        sb      <= bus.b;
                        cnt     <= '0;
                        state   <= SHIFT;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    cnt    <= cnt + 1'b1;
                    // last flags the cycle where cnt reaches N-1, i.e. the MSB on x/y
                    last_q <= (cnt == CW'(N - 2));
                    if (cnt == CW'(N - 1)) begin
                        // counter parks at 0 instead of wrapping past N-1
                        cnt    <= '0;
                        state  <= FLUSH;
                        last_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SUM_CAPTURE_EN
    logic [N-1:0] col;
    logic [N:0]   sum_q;
    logic         sum_valid_q;

    assign bus.sum       = sum_q;
    assign bus.sum_valid = sum_valid_q;

    // Collect the adder's s bits MSB-first; the flush-cycle s is the carry-out and completes the sum.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col         <= '0;
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= 1'b0;
            if (state == SHIFT) begin
                col <= {bus.s, col[N-1:1]};
            end
            if (state == FLUSH) begin
                sum_q       <= {bus.s, col};
                sum_valid_q <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_operand_shifter.sv
// Self-checking bench: per-cycle comparison against a frame-position model plus literal scenarios.
// Includes a behavioural Mealy serial adder so the optional sum capture path can be exercised.
// Works with or without SUM_CAPTURE_EN defined.
module tb_serial_operand_shifter;
    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    serial_operand_shifter_if #(.N(N)) bus ();

    serial_operand_shifter #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef SUM_CAPTURE_EN
    // Mealy serial adder downstream of the shifter: s = x^y^c, carry registered, shares reset.
    logic carry;
    assign bus.s = bus.x ^ bus.y ^ carry;
    always @(posedge clock or negedge reset) begin
        if (!reset) carry <= 1'b0;
        else        carry <= (bus.x & bus.y) | (bus.x & carry) | (bus.y & carry);
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ph: 0 = idle, 1..N = shift cycle presenting bit ph-1, N+1 = flush.
    int           ph = 0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    logic [N:0]   m_sum = '0;
    logic         m_valid = 1'b0;

    function automatic logic bit_at(input logic [N-1:0] v, input int p);
        if (p >= 1 && p <= N) return v[p-1];
        return 1'b0;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph      <= 0;
            m_sum   <= '0;
            m_valid <= 1'b0;
        end else if (ph == 0) begin
            m_valid <= 1'b0;
            if (bus.start) begin
                m_a <= bus.a;
                m_b <= bus.b;
                ph  <= 1;
            end
        end else if (ph <= N) begin
            m_valid <= 1'b0;
            ph      <= ph + 1;
        end else begin
            ph      <= 0;
            m_sum   <= {1'b0, m_a} + {1'b0, m_b};
            m_valid <= 1'b1;
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    always @(negedge clock) begin
        check("ready", bus.ready, ph == 0);
        check("busy",  bus.busy,  ph != 0);
        check("last",  bus.last,  ph == N);
        check("done",  bus.done,  ph == N + 1);
        check("x",     bus.x,     bit_at(m_a, ph));
        check("y",     bus.y,     bit_at(m_b, ph));
`ifdef SUM_CAPTURE_EN
        check("sum_valid", bus.sum_valid, m_valid);
        check("sum",       bus.sum,       m_sum);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one frame from IDLE; returns the serial x/y/last bit patterns (bit i = shift cycle i).
    task automatic run_frame(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input bit noise,
                             output logic [N-1:0] xs, output logic [N-1:0] ys,
                             output logic [N-1:0] ls, output logic fl_done,
                             output logic fl_xy, output logic [N:0] sumv, output logic sv);
        bus.start = 1'b1;
        bus.a     = ta;
        bus.b     = tb_v;
        tick();
        for (int i = 0; i < N; i++) begin
            bus.start = noise && (i == 1);
            bus.a     = ~ta;
            bus.b     = ~tb_v;
            if (noise) check("ready_in_shift", bus.ready, 1'b0);
            xs[i] = bus.x;
            ys[i] = bus.y;
            ls[i] = bus.last;
            tick();
        end
        fl_done   = bus.done;
        fl_xy     = bus.x | bus.y;
        bus.start = noise;
        if (noise) check("ready_in_flush", bus.ready, 1'b0);
        tick();
        bus.start = 1'b0;
`ifdef SUM_CAPTURE_EN
        sumv = bus.sum;
        sv   = bus.sum_valid;
`else
        sumv = '0;
        sv   = 1'b0;
`endif
    endtask

    logic [N-1:0] xs, ys, ls;
    logic         fd, fxy, sv;
    logic [N:0]   sumv;
    logic [11:0]  rdy_hist;
    int           pulses;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #1 reset = 1'b0;

        // 1. reset for 2 cycles
        tick();
        tick();
        check("rst_ready", bus.ready, 1'b1);
        check("rst_flags", {bus.x, bus.y, bus.busy, bus.last, bus.done}, 5'b0);
        reset = 1'b1;
        tick();

        // 2. basic frame
        run_frame(4'b0110, 4'b0011, 1'b0, xs, ys, ls, fd, fxy, sumv, sv);
        check("t2_x_bits", xs, 4'b0110);
        check("t2_y_bits", ys, 4'b0011);
        check("t2_last",   ls, 4'b1000);
        check("t2_done",   fd, 1'b1);
        check("t2_flush_xy", fxy, 1'b0);
`ifdef SUM_CAPTURE_EN
        check("t2_sum", sumv, 5'd9);
        check("t2_sum_valid", sv, 1'b1);
`endif

        // 3. carry-out and carry flush
        run_frame(4'b1111, 4'b1111, 1'b0, xs, ys, ls, fd, fxy, sumv, sv);
        check("t3_x_bits", xs, 4'b1111);
`ifdef SUM_CAPTURE_EN
        check("t3_sum", sumv, 5'd30);
`endif
        run_frame(4'b0000, 4'b0000, 1'b0, xs, ys, ls, fd, fxy, sumv, sv);
        check("t3_zero_x", xs, 4'b0000);
`ifdef SUM_CAPTURE_EN
        check("t3_zero_sum", sumv, 5'd0);
`endif

        // 4. start pulses during SHIFT and FLUSH are ignored
        run_frame(4'b1010, 4'b0101, 1'b1, xs, ys, ls, fd, fxy, sumv, sv);
        check("t4_x_bits", xs, 4'b1010);
        check("t4_y_bits", ys, 4'b0101);
        check("t4_idle_ready", bus.ready, 1'b1);
`ifdef SUM_CAPTURE_EN
        check("t4_sum", sumv, 5'd15);
`endif
        tick();

        // 5. start held: period N+2 with one ready cycle between frames
        bus.a     = 4'b0001;
        bus.b     = 4'b0001;
        bus.start = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            rdy_hist[i] = bus.ready;
`ifdef SUM_CAPTURE_EN
            if (i == 5 || i == 11) begin
                check("t5_sum", bus.sum, 5'd2);
                check("t5_sum_valid", bus.sum_valid, 1'b1);
            end
`endif
            tick();
        end
        check("t5_ready_pattern", rdy_hist, 12'b1000_0010_0000);
        bus.start = 1'b0;
        for (int i = 0; i < N + 3; i++) tick();

        // 6. reset during the 2nd SHIFT cycle
        bus.a     = 4'b1111;
        bus.b     = 4'b1011;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("t6_pre_busy", bus.busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_xyb", {bus.x, bus.y, bus.busy, bus.last, bus.done}, 5'b0);
        check("t6_async_ready", bus.ready, 1'b1);
        @(posedge clock);
        #1 reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 3; i++) begin
`ifdef SUM_CAPTURE_EN
            if (bus.sum_valid) pulses++;
`endif
            if (bus.busy) pulses++;
            tick();
        end
        check("t6_no_frame_after_reset", pulses, 0);
        check("t6_idle_ready", bus.ready, 1'b1);

        // Randomized: random start requests (many while busy) with random operands.
        for (int i = 0; i < 400; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = N'($urandom);
            bus.b     = N'($urandom);
            tick();
        end
        bus.start = 1'b0;
        for (int i = 0; i < N + 3; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_operand_shifter.md
Name: serial_operand_shifter

Overview:
Upstream feeder for the Mealy serial adder. It loads two N-bit operands in parallel on a start request and shifts them out LSB-first on x/y, one bit per clock. It then drives one zero flush cycle so the adder's carry is emitted and cleared before the next operand pair. It also signals busy, last and done around each frame.

Parameters:
N, 4, operand width in bits; legal range 2..32.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 forces the reset state immediately.
start  input  1  request to load a/b and begin a frame; sampled only when ready=1.
a  input  N  operand A; captured on the accepted start edge.
b  input  N  operand B; captured on the accepted start edge.
ready  output  1  1 only in IDLE.
x  output  1  serial bit of A to the adder's x input; registered.
y  output  1  serial bit of B to the adder's y input; registered.
busy  output  1  1 while SHIFT or FLUSH.
last  output  1  1 during the SHIFT cycle that presents the MSB (bit N-1).
done  output  1  one-cycle pulse during FLUSH.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift registers, counter, x, y, busy, last, done all 0; ready=1.
  - Holds as long as reset=0.
- States: IDLE -> SHIFT -> FLUSH -> IDLE.
- IDLE:
  - x=y=0, ready=1.
  - On a rising edge with start=1: sa<=a, sb<=b, cnt<=0, state<=SHIFT.
  - Operands are captured only at this edge; later changes on a/b have no effect on the frame.
- SHIFT:
  - x=sa[0], y=sb[0] visible from the first edge after start; no combinational path from start to x/y.
  - Each edge: sa, sb shift right with zero fill; cnt<=cnt+1.
  - last=1 when cnt==N-1.
  - On the edge with cnt==N-1: state<=FLUSH.
  - Exactly N SHIFT cycles.
- FLUSH:
  - One cycle, x=y=0, done=1, busy=1.
  - The adder's s during this cycle equals the carry-out of the N-bit add, and the adder's carry is cleared.
  - Next edge: state<=IDLE.
- Frame length: N+1 cycles busy.
  - start held continuously gives back-to-back frames with exactly one IDLE cycle between them (period N+2).
- start while busy or during FLUSH is ignored (not queued).
- cnt width is clog2(N) bits; no wrap beyond N-1.
- Reset mid-frame (any state): the frame is abandoned and all outputs go to reset values at once.
  - The adder shares the reset, so its carry is cleared too.
  - After reset is released, the block waits in IDLE for a new start.
- All outputs are registered or decoded from state only; none depend combinationally on start, a or b.

Optional Feature:
SUM_CAPTURE_EN
- Defined:
  - Adds input s (1 bit, the adder's sum output) and outputs sum (N+1 bits) and sum_valid (1 bit).
  - On every rising edge in SHIFT and FLUSH, s is shifted into a collector from the MSB end.
  - On the FLUSH->IDLE edge, sum<={carry, s bits MSB..LSB}, i.e. the full A+B, and sum_valid pulses 1 for one cycle (in IDLE).
  - sum holds until the next frame completes.
  - Reset clears sum and sum_valid to 0.
  - An abandoned frame never updates sum.
- Undefined: the s, sum and sum_valid ports do not exist; behaviour is otherwise identical.

Test Plan:
1. Reset 0 for 2 cycles, then 1 -> ready=1; x=y=busy=last=done=0 throughout.
2. Start with a=0110, b=0011 (N=4) -> x=0,1,1,0 and y=1,1,0,0 on 4 SHIFT cycles; last on the 4th; FLUSH with x=y=0, done=1. With SUM_CAPTURE_EN: sum=01001 (9), sum_valid pulse one cycle later.
3. Start with a=1111, b=1111 -> adder s=0,1,1,1, then 1 in FLUSH; sum=11110 (30). Next frame with a=b=0 gives sum=00000, proving the carry was flushed.
4. Pulse start again during SHIFT and during FLUSH with different operands -> ignored; frame output unchanged; ready stays 0 until IDLE.
5. Hold start=1 continuously with a=0001, b=0001 -> frames repeat every 6 cycles; ready high for exactly 1 cycle between frames; each sum=00010.
6. Drop reset to 0 on the 2nd SHIFT cycle -> x, y, busy go 0 immediately (before the next edge); after release, state is IDLE; sum_valid never pulses for that frame.
